// File: rtl/l1_mem_pkg.sv
//==============================================================================
// Module      : l1_mem_pkg
// Description : Shared types and default widths for the L1-to-memory arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package l1_mem_pkg;

    localparam int L1_ADDR_WIDTH = 32;
    localparam int L1_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Request image latched toward lower memory at grant time
    typedef struct packed {
        logic [L1_ADDR_WIDTH-1:0] addr;
        logic                     we;
        logic [L1_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/l1_rr_picker.sv
//==============================================================================
// Module      : l1_rr_picker
// Description : Combinational two-way round-robin choice between I and D.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module l1_rr_picker (
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_grant_d,
    output logic o_any,
    output logic o_pick_d
);

    assign o_any    = i_req_i | i_req_d;
    // D wins when alone, or on a tie when I was served last
    assign o_pick_d = i_req_d & (~i_req_i | ~i_last_grant_d);

endmodule

`default_nettype wire

// File: rtl/l1_mem_arbiter.sv
//==============================================================================
// Module      : l1_mem_arbiter
// Description : Round-robin arbiter sharing one lower-memory port between the
//               I-cache and D-cache. Optional counters: L1_MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module l1_mem_arbiter
    import l1_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
    parameter int DATA_WIDTH = L1_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_request,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_response_data,
    input  logic                  mem_ready,
    output logic [1:0]            arb_state,
    output logic                  grant_d
`ifdef L1_MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_i_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_conflict_cycles
`endif
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    mem_req_t              r_req;
    mem_req_t              w_sel_req;
    logic                  r_mem_request;
    logic                  r_grant_d;
    logic                  r_last_grant_d;
    logic                  r_i_ready;
    logic                  r_d_ready;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  w_any;
    logic                  w_pick_d;
    logic                  w_grant;
    logic                  w_complete;
    logic                  w_granted_req;

    l1_rr_picker u_picker (
        .i_req_i        (i_req),
        .i_req_d        (d_req),
        .i_last_grant_d (r_last_grant_d),
        .o_any          (w_any),
        .o_pick_d       (w_pick_d)
    );

    assign w_granted_req = r_grant_d ? d_req : i_req;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; RELEASE waits for req to drop so a stale request is not re-served
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any)          w_state_next = BUSY;
            BUSY:    if (mem_ready)      w_state_next = RELEASE;
            RELEASE: if (!w_granted_req) w_state_next = IDLE;
            default:                     w_state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_grant    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE:    w_grant    = w_any;
            BUSY:    w_complete = mem_ready;
            default: ;
        endcase
    end

    // I-cache fills are reads, so we and wdata stay zero
    always_comb begin
        w_sel_req = '0;
        if (w_pick_d) begin
            w_sel_req.addr  = L1_ADDR_WIDTH'(d_addr);
            w_sel_req.we    = d_we;
            w_sel_req.wdata = L1_DATA_WIDTH'(d_wdata);
        end else begin
            w_sel_req.addr  = L1_ADDR_WIDTH'(i_addr);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_request  <= 1'b0;
            r_req          <= '0;
            r_grant_d      <= 1'b0;
            r_last_grant_d <= 1'b1;
            r_i_ready      <= 1'b0;
            r_d_ready      <= 1'b0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
        end else begin
            r_i_ready <= w_complete & ~r_grant_d;
            r_d_ready <= w_complete &  r_grant_d;
            if (w_grant) begin
                r_req          <= w_sel_req;
                r_mem_request  <= 1'b1;
                r_grant_d      <= w_pick_d;
                r_last_grant_d <= w_pick_d;
            end else if (w_complete) begin
                r_mem_request  <= 1'b0;
                r_req.we       <= 1'b0;
            end
            if (w_complete && !r_grant_d) begin
                r_i_rdata <= mem_response_data;
            end
            if (w_complete && r_grant_d) begin
                r_d_rdata <= mem_response_data;
            end
        end
    end

`ifdef L1_MEM_ARB_PERF_EN
    logic [31:0] r_perf_i_grants;
    logic [31:0] r_perf_d_grants;
    logic [31:0] r_perf_conflict;
    logic        w_conflict;

    always_comb begin
        w_conflict = 1'b0;
        case (r_state)
            IDLE:    w_conflict = i_req & d_req;
            BUSY:    w_conflict = r_grant_d ? i_req : d_req;
            default: w_conflict = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_i_grants <= '0;
            r_perf_d_grants <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_grant && !w_pick_d) r_perf_i_grants <= r_perf_i_grants + 32'd1;
            if (w_grant &&  w_pick_d) r_perf_d_grants <= r_perf_d_grants + 32'd1;
            if (w_conflict)           r_perf_conflict <= r_perf_conflict + 32'd1;
        end
    end

    assign perf_i_grants        = r_perf_i_grants;
    assign perf_d_grants        = r_perf_d_grants;
    assign perf_conflict_cycles = r_perf_conflict;
`endif

    assign i_ready          = r_i_ready;
    assign d_ready          = r_d_ready;
    assign i_rdata          = r_i_rdata;
    assign d_rdata          = r_d_rdata;
    assign mem_request      = r_mem_request;
    assign mem_address      = ADDR_WIDTH'(r_req.addr);
    assign mem_write_enable = r_req.we;
    assign mem_write_data   = DATA_WIDTH'(r_req.wdata);
    assign arb_state        = r_state;
    assign grant_d          = r_grant_d;

endmodule

`default_nettype wire

// File: tb/tb_l1_mem_arbiter.sv
//==============================================================================
// Module      : tb_l1_mem_arbiter
// Description : Directed self-checking bench for l1_mem_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_l1_mem_arbiter;

    logic        clk;
    logic        rstn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_request;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_response_data;
    logic        mem_ready;
    logic [1:0]  arb_state;
    logic        grant_d;
`ifdef L1_MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_conflict_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    l1_mem_arbiter dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_req             (i_req),
        .i_addr            (i_addr),
        .i_ready           (i_ready),
        .i_rdata           (i_rdata),
        .d_req             (d_req),
        .d_addr            (d_addr),
        .d_we              (d_we),
        .d_wdata           (d_wdata),
        .d_ready           (d_ready),
        .d_rdata           (d_rdata),
        .mem_request       (mem_request),
        .mem_address       (mem_address),
        .mem_write_enable  (mem_write_enable),
        .mem_write_data    (mem_write_data),
        .mem_response_data (mem_response_data),
        .mem_ready         (mem_ready),
        .arb_state         (arb_state),
        .grant_d           (grant_d)
`ifdef L1_MEM_ARB_PERF_EN
        ,
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
        d_we = 1'b0; d_wdata = '0; mem_response_data = '0; mem_ready = 1'b0;
        #12;
        check_eq("rst_mem_request", mem_request, 0);
        check_eq("rst_state", arb_state, 0);
        check_eq("rst_grant_d", grant_d, 0);
        check_eq("rst_ready", {i_ready, d_ready}, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Single I fill, memory answers after 3 cycles
        i_req = 1'b1; i_addr = 32'h0000_0100;
        tick();
        check_eq("t1_mem_request", mem_request, 1);
        check_eq("t1_mem_address", mem_address, 32'h100);
        check_eq("t1_we", mem_write_enable, 0);
        check_eq("t1_state_busy", arb_state, 1);
        check_eq("t1_grant_d", grant_d, 0);
        tick();
        tick();
        check_eq("t1_held_req", mem_request, 1);
        mem_ready = 1'b1; mem_response_data = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        check_eq("t1_i_ready", i_ready, 1);
        check_eq("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
        check_eq("t1_d_ready", d_ready, 0);
        check_eq("t1_mem_req_drop", mem_request, 0);
        check_eq("t1_state_rel", arb_state, 2);
        i_req = 1'b0;
        tick();
        check_eq("t1_i_ready_pulse", i_ready, 0);
        check_eq("t1_state_idle", arb_state, 0);
        check_eq("t1_rdata_hold", i_rdata, 32'hDEAD_BEEF);

        // Reset, then simultaneous requests: I wins the first tie
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0;
        tick();
        check_eq("t2_grant_i", grant_d, 0);
        check_eq("t2_addr_i", mem_address, 32'h300);
        mem_ready = 1'b1; mem_response_data = 32'h1111_2222;
        tick();
        mem_ready = 1'b0;
        check_eq("t2_i_ready", i_ready, 1);
        check_eq("t2_d_ready_quiet", d_ready, 0);
        i_req = 1'b0;
        tick();
        check_eq("t2_idle_gap", arb_state, 0);
        tick();
        check_eq("t2_grant_d", grant_d, 1);
        check_eq("t2_addr_d", mem_address, 32'h200);
        check_eq("t2_mem_request_d", mem_request, 1);
        mem_ready = 1'b1; mem_response_data = 32'h3333_4444;
        tick();
        mem_ready = 1'b0;
        check_eq("t2_d_ready", d_ready, 1);
        check_eq("t2_d_rdata", d_rdata, 32'h3333_4444);
        check_eq("t2_i_ready_quiet", i_ready, 0);
        d_req = 1'b0;
        tick();

        // D write-through held stable through BUSY
        d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h1234_5678; d_addr = 32'h40;
        tick();
        check_eq("t3_we", mem_write_enable, 1);
        check_eq("t3_wdata", mem_write_data, 32'h1234_5678);
        check_eq("t3_addr", mem_address, 32'h40);
        tick();
        tick();
        check_eq("t3_we_held", mem_write_enable, 1);
        check_eq("t3_wdata_held", mem_write_data, 32'h1234_5678);
        mem_ready = 1'b1; mem_response_data = 32'h0;
        tick();
        mem_ready = 1'b0;
        check_eq("t3_d_ready", d_ready, 1);
        check_eq("t3_we_clear", mem_write_enable, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check_eq("t3_d_ready_once", d_ready, 0);

        // Both clients continuously requesting: grants alternate I,D,I,D,I,D
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h1000; d_addr = 32'h2000;
        tick();
        for (int k = 0; k < 6; k++) begin
            logic exp_d;
            exp_d = k[0];
            check_eq("rr_grant", grant_d, exp_d);
            check_eq("rr_addr", mem_address, exp_d ? 32'h2000 : 32'h1000);
            mem_ready = 1'b1; mem_response_data = 32'hA0 + k;
            tick();
            mem_ready = 1'b0;
            check_eq("rr_i_ready", i_ready, !exp_d);
            check_eq("rr_d_ready", d_ready, exp_d);
            check_eq("rr_rdata", exp_d ? d_rdata : i_rdata, 32'hA0 + k);
            if (exp_d) d_req = 1'b0; else i_req = 1'b0;
            if (k == 5) begin i_req = 1'b0; d_req = 1'b0; end
            tick();
            check_eq("rr_idle", arb_state, 0);
            if (k < 5) begin
                if (exp_d) d_req = 1'b1; else i_req = 1'b1;
                tick();
            end
        end

        // Winner holds req two cycles past ready; pending D waits for release
        i_req = 1'b1; i_addr = 32'h500;
        tick();
        check_eq("t5_grant_i", grant_d, 0);
        d_req = 1'b1; d_addr = 32'h600;
        mem_ready = 1'b1; mem_response_data = 32'h5555_0000;
        tick();
        mem_ready = 1'b0;
        check_eq("t5_i_ready", i_ready, 1);
        for (int j = 0; j < 2; j++) begin
            tick();
            check_eq("t5_stay_release", arb_state, 2);
            check_eq("t5_no_second_req", mem_request, 0);
            check_eq("t5_no_repulse", i_ready, 0);
        end
        i_req = 1'b0;
        tick();
        check_eq("t5_idle", arb_state, 0);
        check_eq("t5_idle_no_req", mem_request, 0);
        tick();
        check_eq("t5_grant_d", grant_d, 1);
        check_eq("t5_addr_d", mem_address, 32'h600);
        mem_ready = 1'b1; mem_response_data = 32'h6666_0000;
        tick();
        mem_ready = 1'b0;
        check_eq("t5_d_ready", d_ready, 1);
        d_req = 1'b0;
        tick();
        // Stray mem_ready in IDLE is ignored
        mem_ready = 1'b1; mem_response_data = 32'hBAD0_BAD0;
        tick();
        mem_ready = 1'b0;
        check_eq("t5_stray_ready", {i_ready, d_ready}, 0);
        check_eq("t5_stray_state", arb_state, 0);
        check_eq("t5_stray_rdata", d_rdata, 32'h6666_0000);

        // Reset while BUSY abandons the transaction
        i_req = 1'b1; i_addr = 32'h700;
        tick();
        check_eq("t6_busy", arb_state, 1);
        rstn = 1'b0;
        #1;
        check_eq("t6_rst_req", mem_request, 0);
        check_eq("t6_rst_state", arb_state, 0);
        check_eq("t6_rst_addr", mem_address, 0);
        check_eq("t6_rst_rdata", i_rdata, 0);
        i_req = 1'b0;
        mem_ready = 1'b1; mem_response_data = 32'h7777_7777;
        tick();
        mem_ready = 1'b0;
        check_eq("t6_no_ready", {i_ready, d_ready}, 0);
        rstn = 1'b1;
        tick();
        i_req = 1'b1; i_addr = 32'h800;
        tick();
        check_eq("t6_new_req", mem_request, 1);
        check_eq("t6_new_addr", mem_address, 32'h800);
        mem_ready = 1'b1; mem_response_data = 32'h8888_8888;
        tick();
        mem_ready = 1'b0;
        check_eq("t6_new_ready", i_ready, 1);
        check_eq("t6_new_rdata", i_rdata, 32'h8888_8888);
        i_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
